// File: rtl/fd_multiplier_8bits.sv
`default_nettype none
// ============================================================================
// Module   : fd_multiplier_8bits
// Brief    : 8x8 unsigned multiplier datapath built from a 4x4 product ROM,
//            sequenced by external load/select strobes.
// Revision : 1.0 - initial release
// ============================================================================
module fd_multiplier_8bits (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        LD_XY,
  input  logic        LD_DE0,
  input  logic        LD_A,
  input  logic        LD_B,
  input  logic        LD_DE1,
  input  logic [1:0]  SELROM,
  input  logic [1:0]  SELSOMA,
  output logic [15:0] result,
  output logic        PRONTO
);

  localparam logic [1:0] c_SOMA_HOLD  = 2'd0;
  localparam logic [1:0] c_SOMA_CONCAT = 2'd1;
  localparam logic [1:0] c_SOMA_ADD_A = 2'd2;
  localparam logic [1:0] c_SOMA_ADD_B = 2'd3;

  logic [7:0]  x_q, y_q;
  logic [7:0]  de0_q, a_q, b_q, de1_q;
  logic [15:0] r_q, r_d;
  logic        pronto_q, pronto_d;

  logic [3:0]  w_rom_a, w_rom_b;
  logic [7:0]  w_rom_out;

  always_comb begin
    w_rom_a = x_q[3:0];
    w_rom_b = y_q[3:0];
    case (SELROM)
      2'd0: begin w_rom_a = x_q[3:0]; w_rom_b = y_q[3:0]; end
      2'd1: begin w_rom_a = x_q[3:0]; w_rom_b = y_q[7:4]; end
      2'd2: begin w_rom_a = x_q[7:4]; w_rom_b = y_q[3:0]; end
      default: begin w_rom_a = x_q[7:4]; w_rom_b = y_q[7:4]; end
    endcase
  end

  // 4x4 product table; 15*15 fits in 8 bits so no truncation occurs.
  assign w_rom_out = {4'b0000, w_rom_a} * {4'b0000, w_rom_b};

  always_comb begin
    r_d      = r_q;
    pronto_d = pronto_q;
    case (SELSOMA)
      c_SOMA_HOLD:   r_d = r_q;
      c_SOMA_CONCAT: r_d = {de1_q, de0_q};
      c_SOMA_ADD_A:  r_d = r_q + {4'b0000, a_q, 4'b0000};
      c_SOMA_ADD_B: begin
        r_d      = r_q + {4'b0000, b_q, 4'b0000};
        pronto_d = 1'b1;
      end
      default:       r_d = r_q;
    endcase
    // New operands invalidate the result even if the last add is in flight.
    if (LD_XY) pronto_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      de0_q    <= 8'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      de1_q    <= 8'd0;
      r_q      <= 16'd0;
      pronto_q <= 1'b0;
    end else begin
      if (LD_XY) begin
        x_q <= x;
        y_q <= y;
      end
      if (LD_DE0) de0_q <= w_rom_out;
      if (LD_A)   a_q   <= w_rom_out;
      if (LD_B)   b_q   <= w_rom_out;
      if (LD_DE1) de1_q <= w_rom_out;
      r_q      <= r_d;
      pronto_q <= pronto_d;
    end
  end

  assign result = r_q;
  assign PRONTO = pronto_q;

endmodule
`default_nettype wire

// File: tb/tb_fd_multiplier_8bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_fd_multiplier_8bits
// Brief    : Self-checking bench for fd_multiplier_8bits against an
//            arithmetic nibble-product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fd_multiplier_8bits;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  x = 8'd0, y = 8'd0;
  logic        LD_XY = 1'b0, LD_DE0 = 1'b0, LD_A = 1'b0, LD_B = 1'b0, LD_DE1 = 1'b0;
  logic [1:0]  SELROM = 2'd0, SELSOMA = 2'd0;
  logic [15:0] result;
  logic        PRONTO;

  int checks = 0;
  int errors = 0;

  fd_multiplier_8bits dut (
    .CLK(CLK), .RESET(RESET), .x(x), .y(y),
    .LD_XY(LD_XY), .LD_DE0(LD_DE0), .LD_A(LD_A), .LD_B(LD_B), .LD_DE1(LD_DE1),
    .SELROM(SELROM), .SELSOMA(SELSOMA), .result(result), .PRONTO(PRONTO)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: product decomposed as xH*yH*256 + xL*yL + 16*(xL*yH + xH*yL).
  function automatic int unsigned m_step1(input int unsigned a, input int unsigned b);
    return (a / 16) * (b / 16) * 256 + (a % 16) * (b % 16);
  endfunction
  function automatic int unsigned m_step2(input int unsigned a, input int unsigned b);
    return m_step1(a, b) + 16 * (a % 16) * (b / 16);
  endfunction

  task automatic clear_strobes();
    LD_XY = 0; LD_DE0 = 0; LD_A = 0; LD_B = 0; LD_DE1 = 0;
    SELROM = 2'd0; SELSOMA = 2'd0;
  endtask

  task automatic load_xy(input logic [7:0] xv, input logic [7:0] yv);
    x = xv; y = yv; LD_XY = 1; step();
    clear_strobes();
  endtask

  task automatic load_pps();
    SELROM = 2'd0; LD_DE0 = 1; step(); LD_DE0 = 0;
    SELROM = 2'd1; LD_A   = 1; step(); LD_A   = 0;
    SELROM = 2'd2; LD_B   = 1; step(); LD_B   = 0;
    SELROM = 2'd3; LD_DE1 = 1; step(); LD_DE1 = 0;
    SELROM = 2'd0;
  endtask

  task automatic sum_steps(input string tag, input logic [7:0] xv, input logic [7:0] yv);
    int unsigned prod;
    prod = int'(xv) * int'(yv);
    SELSOMA = 2'd1; step();
    check({tag, "_step1"}, result, 16'(m_step1(xv, yv)));
    check({tag, "_pronto_pre"}, {15'd0, PRONTO}, 16'd0);
    SELSOMA = 2'd2; step();
    check({tag, "_step2"}, result, 16'(m_step2(xv, yv)));
    SELSOMA = 2'd3; step();
    SELSOMA = 2'd0;
    check({tag, "_final"}, result, 16'(prod));
    check({tag, "_pronto"}, {15'd0, PRONTO}, 16'd1);
  endtask

  task automatic full_product(input string tag, input logic [7:0] xv, input logic [7:0] yv);
    load_xy(xv, yv);
    check({tag, "_pronto_clr"}, {15'd0, PRONTO}, 16'd0);
    load_pps();
    sum_steps(tag, xv, yv);
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [15:0] held;

    // Reset held low while strobes toggle randomly.
    for (int i = 0; i < 4; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      {LD_XY, LD_DE0, LD_A, LD_B, LD_DE1} = 5'($urandom);
      SELROM = 2'($urandom); SELSOMA = 2'($urandom);
      step();
      check("rst_result", result, 16'd0);
      check("rst_pronto", {15'd0, PRONTO}, 16'd0);
    end
    clear_strobes();
    RESET = 1; step(); step();
    check("rel_result", result, 16'd0);
    check("rel_pronto", {15'd0, PRONTO}, 16'd0);

    full_product("p5x7", 8'd5, 8'd7);
    full_product("p255", 8'd255, 8'd255);
    full_product("pABxCD", 8'hAB, 8'hCD);

    // Asynchronous reset between the concat and the first add.
    load_xy(8'd200, 8'd150);
    load_pps();
    SELSOMA = 2'd1; step();
    check("mid_step1", result, 16'(m_step1(200, 150)));
    SELSOMA = 2'd2;
    #2 RESET = 0;
    #1;
    check("async_result", result, 16'd0);
    check("async_pronto", {15'd0, PRONTO}, 16'd0);
    step();
    check("async_hold", result, 16'd0);
    clear_strobes();
    #2 RESET = 1;
    step();
    SELSOMA = 2'd1; step(); SELSOMA = 2'd0;
    check("post_rst_cleared", result, 16'd0);
    full_product("p3x4", 8'd3, 8'd4);

    // New operands clear PRONTO but leave the old result until concat.
    held = result;
    load_xy(8'd2, 8'd9);
    check("new_pronto", {15'd0, PRONTO}, 16'd0);
    check("new_hold", result, held);
    load_pps();
    check("new_hold_pp", result, held);
    sum_steps("p2x9", 8'd2, 8'd9);

    // Random operands against the model.
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      full_product($sformatf("rnd%0d_%0dx%0d", i, rx, ry), rx, ry);
    end

    // Holding the last add keeps accumulating B.
    rx = 8'($urandom); ry = 8'($urandom);
    full_product("acc_base", rx, ry);
    SELSOMA = 2'd3; step(); SELSOMA = 2'd0;
    check("acc_extra", result,
          16'(int'(rx) * int'(ry) + 16 * (int'(rx) / 16) * (int'(ry) % 16)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
